// File: rtl/brief_kp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : brief_kp_scheduler_if
// Purpose  : Bundles the keypoint push port, window-centre feed, BRIEF head
//            and return ports, and the descriptor output port of
//            brief_kp_scheduler.
// Modports : slave  - used by the scheduler (drives o_*, samples i_*)
//            master - used by the surrounding logic / testbench
// Options  : BRIEF_SCHED_STATS_EN adds o_stale_cnt, o_ovf_cnt, o_spur_cnt
// Revision : 1.0 - initial release
// ============================================================================
interface brief_kp_scheduler_if #(
    parameter int CW = 10,
    parameter int TW = 12
);
    logic                 i_frame_start;
    logic                 i_kp_valid;
    logic                 o_kp_ready;
    logic [CW-1:0]        i_kp_x;
    logic [CW-1:0]        i_kp_y;
    logic [7:0]           i_kp_score;
    logic signed [TW-1:0] i_kp_sin;
    logic signed [TW-1:0] i_kp_cos;
    logic                 i_win_valid;
    logic [CW-1:0]        i_win_x;
    logic [CW-1:0]        i_win_y;
    logic [CW-1:0]        o_brief_coor_x;
    logic [CW-1:0]        o_brief_coor_y;
    logic [7:0]           o_brief_score;
    logic signed [TW-1:0] o_brief_sin;
    logic signed [TW-1:0] o_brief_cos;
    logic                 i_brief_flag;
    logic [CW-1:0]        i_brief_x;
    logic [CW-1:0]        i_brief_y;
    logic [255:0]         i_brief_desc;
    logic [7:0]           i_brief_score;
    logic                 o_desc_valid;
    logic                 i_desc_ready;
    logic [CW-1:0]        o_desc_x;
    logic [CW-1:0]        o_desc_y;
    logic [255:0]         o_desc;
    logic [7:0]           o_desc_score;
    logic                 o_busy;
`ifdef BRIEF_SCHED_STATS_EN
    logic [15:0]          o_stale_cnt;
    logic [15:0]          o_ovf_cnt;
    logic [15:0]          o_spur_cnt;

    modport slave (
        input  i_frame_start, i_kp_valid, i_kp_x, i_kp_y, i_kp_score, i_kp_sin, i_kp_cos,
        input  i_win_valid, i_win_x, i_win_y,
        input  i_brief_flag, i_brief_x, i_brief_y, i_brief_desc, i_brief_score, i_desc_ready,
        output o_kp_ready, o_brief_coor_x, o_brief_coor_y, o_brief_score, o_brief_sin, o_brief_cos,
        output o_desc_valid, o_desc_x, o_desc_y, o_desc, o_desc_score, o_busy,
        output o_stale_cnt, o_ovf_cnt, o_spur_cnt
    );
    modport master (
        output i_frame_start, i_kp_valid, i_kp_x, i_kp_y, i_kp_score, i_kp_sin, i_kp_cos,
        output i_win_valid, i_win_x, i_win_y,
        output i_brief_flag, i_brief_x, i_brief_y, i_brief_desc, i_brief_score, i_desc_ready,
        input  o_kp_ready, o_brief_coor_x, o_brief_coor_y, o_brief_score, o_brief_sin, o_brief_cos,
        input  o_desc_valid, o_desc_x, o_desc_y, o_desc, o_desc_score, o_busy,
        input  o_stale_cnt, o_ovf_cnt, o_spur_cnt
    );
`else
    modport slave (
        input  i_frame_start, i_kp_valid, i_kp_x, i_kp_y, i_kp_score, i_kp_sin, i_kp_cos,
        input  i_win_valid, i_win_x, i_win_y,
        input  i_brief_flag, i_brief_x, i_brief_y, i_brief_desc, i_brief_score, i_desc_ready,
        output o_kp_ready, o_brief_coor_x, o_brief_coor_y, o_brief_score, o_brief_sin, o_brief_cos,
        output o_desc_valid, o_desc_x, o_desc_y, o_desc, o_desc_score, o_busy
    );
    modport master (
        output i_frame_start, i_kp_valid, i_kp_x, i_kp_y, i_kp_score, i_kp_sin, i_kp_cos,
        output i_win_valid, i_win_x, i_win_y,
        output i_brief_flag, i_brief_x, i_brief_y, i_brief_desc, i_brief_score, i_desc_ready,
        input  o_kp_ready, o_brief_coor_x, o_brief_coor_y, o_brief_score, o_brief_sin, o_brief_cos,
        input  o_desc_valid, o_desc_x, o_desc_y, o_desc, o_desc_score, o_busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/brief_kp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : brief_kp_scheduler
// Purpose  : Queues oriented keypoints, presents the FIFO head to the BRIEF
//            stage until the sliding-window centre reaches it (or passes it),
//            and buffers completed descriptors for a valid/ready consumer.
// Ports    : i_clk      - clock
//            i_rst_n    - asynchronous active-low reset
//            bus        - brief_kp_scheduler_if.slave (keypoint push, window,
//                         BRIEF head/return, descriptor output, busy)
// Options  : BRIEF_SCHED_STATS_EN adds saturating stale/overflow/spurious
//            event counters on the interface.
// Revision : 1.0 - initial release
// ============================================================================
module brief_kp_scheduler #(
    parameter int DEPTH = 8,
    parameter int CW    = 10,
    parameter int TW    = 12
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    brief_kp_scheduler_if.slave    bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_EW = 2*CW + 8 + 2*TW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_EW-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic [c_AW:0]      w_count_nxt;
    logic [2:0]         r_inflight;
    logic               r_desc_valid;
    logic [CW-1:0]      r_desc_x;
    logic [CW-1:0]      r_desc_y;
    logic [255:0]       r_desc;
    logic [7:0]         r_desc_score;

    logic [CW-1:0]      w_hx;
    logic [CW-1:0]      w_hy;
    logic [7:0]         w_hscore;
    logic [TW-1:0]      w_hsin;
    logic [TW-1:0]      w_hcos;
    logic               w_push_acc;
    logic               w_push_wr;
    logic               w_match;
    logic               w_stale;
    logic               w_pop;
    logic               w_flag_ok;
    logic               w_spur;
    logic               w_ovf;

    assign {w_hx, w_hy, w_hscore, w_hsin, w_hcos} = r_mem[r_rd_ptr];

    assign bus.o_kp_ready = (r_count != (c_AW+1)'(DEPTH));
    // Frame start overrides push and pop in the same cycle.
    assign w_push_acc = bus.i_kp_valid && bus.o_kp_ready && !bus.i_frame_start;
    // Coordinate 0 is never matched by BRIEF, so such keypoints are swallowed.
    assign w_push_wr  = w_push_acc && (bus.i_kp_x != '0) && (bus.i_kp_y != '0);

    assign w_match = (r_state == S_WAIT) && !bus.i_frame_start && bus.i_win_valid &&
                     (bus.i_win_x == w_hx) && (bus.i_win_y == w_hy);
    // Window has passed the head in raster order: it can never match now.
    assign w_stale = (r_state == S_WAIT) && !bus.i_frame_start && bus.i_win_valid &&
                     ((bus.i_win_y > w_hy) || ((bus.i_win_y == w_hy) && (bus.i_win_x > w_hx)));
    assign w_pop   = w_match || w_stale;

    assign w_flag_ok = bus.i_brief_flag && !bus.i_frame_start && (r_inflight != 3'd0);
    assign w_spur    = bus.i_brief_flag && !bus.i_frame_start && (r_inflight == 3'd0);
    assign w_ovf     = w_flag_ok && r_desc_valid && !bus.i_desc_ready;

    always_comb begin
        w_count_nxt = r_count + (c_AW+1)'(w_push_wr) - (c_AW+1)'(w_pop);
        if (bus.i_frame_start) begin
            w_count_nxt = '0;
        end
    end

    // Next-state and BRIEF head outputs.
    always_comb begin
        w_state_nxt        = r_state;
        bus.o_brief_coor_x = '0;
        bus.o_brief_coor_y = '0;
        bus.o_brief_score  = '0;
        bus.o_brief_sin    = '0;
        bus.o_brief_cos    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_push_wr) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.o_brief_coor_x = w_hx;
                bus.o_brief_coor_y = w_hy;
                bus.o_brief_score  = w_hscore;
                bus.o_brief_sin    = w_hsin;
                bus.o_brief_cos    = w_hcos;
                if (w_count_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.i_frame_start) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage needs no reset: contents are only observed while count != 0.
    always_ff @(posedge i_clk) begin
        if (w_push_wr) begin
            r_mem[r_wr_ptr] <= {bus.i_kp_x, bus.i_kp_y, bus.i_kp_score, bus.i_kp_sin, bus.i_kp_cos};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 3'd0;
        end else begin
            r_count <= w_count_nxt;
            if (bus.i_frame_start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_inflight <= 3'd0;
            end else begin
                if (w_push_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_match && !w_flag_ok && (r_inflight != 3'd7)) begin
                    r_inflight <= r_inflight + 3'd1;
                end else if (!w_match && w_flag_ok) begin
                    r_inflight <= r_inflight - 3'd1;
                end
            end
        end
    end

    // Single-entry descriptor holding register; a flag that finds it
    // occupied and not being drained is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_desc_valid <= 1'b0;
            r_desc_x     <= '0;
            r_desc_y     <= '0;
            r_desc       <= '0;
            r_desc_score <= '0;
        end else if (bus.i_frame_start) begin
            r_desc_valid <= 1'b0;
        end else if (w_flag_ok && !w_ovf) begin
            r_desc_valid <= 1'b1;
            r_desc_x     <= bus.i_brief_x;
            r_desc_y     <= bus.i_brief_y;
            r_desc       <= bus.i_brief_desc;
            r_desc_score <= bus.i_brief_score;
        end else if (bus.i_desc_ready) begin
            r_desc_valid <= 1'b0;
        end
    end

    assign bus.o_desc_valid = r_desc_valid;
    assign bus.o_desc_x     = r_desc_x;
    assign bus.o_desc_y     = r_desc_y;
    assign bus.o_desc       = r_desc;
    assign bus.o_desc_score = r_desc_score;
    assign bus.o_busy       = (r_count != '0) || (r_inflight != 3'd0) || r_desc_valid;

`ifdef BRIEF_SCHED_STATS_EN
    logic [15:0] r_stale_cnt;
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_spur_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stale_cnt <= '0;
            r_ovf_cnt   <= '0;
            r_spur_cnt  <= '0;
        end else begin
            if (w_stale && (r_stale_cnt != 16'hFFFF)) r_stale_cnt <= r_stale_cnt + 16'd1;
            if (w_ovf   && (r_ovf_cnt   != 16'hFFFF)) r_ovf_cnt   <= r_ovf_cnt   + 16'd1;
            if (w_spur  && (r_spur_cnt  != 16'hFFFF)) r_spur_cnt  <= r_spur_cnt  + 16'd1;
        end
    end

    assign bus.o_stale_cnt = r_stale_cnt;
    assign bus.o_ovf_cnt   = r_ovf_cnt;
    assign bus.o_spur_cnt  = r_spur_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/brief_kp_scheduler.md
Name: brief_kp_scheduler

Overview:
Sequences oriented keypoints into the BRIEF descriptor stage. Keypoints (coord, score, sin/cos) from the orientation stage go into a small FIFO. The head entry is presented to BRIEF until the sliding-window centre reaches its coordinate. Completed descriptors are collected from BRIEF and handed downstream through a valid/ready port.

Parameters:
DEPTH, 8, keypoint FIFO entries (power of 2, ≥2)
CW, 10, coordinate width
TW, 12, signed sin/cos width (Q1.10)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_frame_start  in  1  single-cycle pulse; flushes FIFO and in-flight state
i_kp_valid  in  1  keypoint offered
o_kp_ready  out  1  FIFO not full
i_kp_x, i_kp_y  in  CW  keypoint coordinate
i_kp_score  in  8  keypoint score
i_kp_sin, i_kp_cos  in  TW  orientation
i_win_valid  in  1  window coordinate valid this cycle
i_win_x, i_win_y  in  CW  current window-centre coordinate, raster order
o_brief_coor_x, o_brief_coor_y  out  CW  head coordinate to BRIEF
o_brief_score  out  8  head score
o_brief_sin, o_brief_cos  out  TW  head orientation
i_brief_flag  in  1  BRIEF descriptor valid
i_brief_x, i_brief_y  in  CW  BRIEF output coordinate
i_brief_desc  in  256  BRIEF descriptor
i_brief_score  in  8  BRIEF output score
o_desc_valid  out  1  descriptor available
i_desc_ready  in  1  downstream accepts
o_desc_x, o_desc_y  out  CW  descriptor coordinate
o_desc  out  256  descriptor
o_desc_score  out  8  descriptor score
o_busy  out  1  FIFO non-empty or descriptor in flight

Behaviour:
- Reset: FIFO empty, state IDLE. o_kp_ready=1. All o_brief_* = 0, o_desc_valid=0, o_desc_*=0, o_busy=0.
- Push: when i_kp_valid && o_kp_ready.
  - Keypoints with x==0 or y==0 are accepted but discarded, because BRIEF ignores coordinate 0.
  - Push while full is impossible, since o_kp_ready=0 when full.
- FSM states:
  - IDLE: FIFO empty; o_brief_* = 0. Go to WAIT on the cycle after the first push.
  - WAIT: o_brief_* driven combinationally from the FIFO head.
    - Match: i_win_valid && win==head. Pop the head, increment in-flight count, stay in WAIT, or go to IDLE if the FIFO becomes empty.
    - Stale: i_win_valid && (win_y>head_y || (win_y==head_y && win_x>head_x)). Pop without issue; the drop is counted when stats are enabled.
    - On the cycle after either pop, the next head is shown. Back-to-back matches on consecutive windows are supported.
- Simultaneous push and pop: both occur; occupancy unchanged.
- Push into an empty FIFO: the entry is not visible as head in the same cycle (1-cycle fall-through latency).
- In-flight counter (3 bits, saturating at 7):
  - +1 on each match pop.
  - −1 on each i_brief_flag.
  - Both in the same cycle: unchanged.
  - i_brief_flag with counter 0: ignored (spurious; counted when stats are enabled).
- Output register, single entry:
  - On i_brief_flag it loads i_brief_x/y/desc/score and sets o_desc_valid.
  - It holds until i_desc_ready.
  - Flag arriving while o_desc_valid && !i_desc_ready: new descriptor dropped, old data kept (overflow).
  - Flag arriving together with a handshake: new data loads, valid stays 1.
- o_busy = (FIFO count≠0) || (in-flight≠0) || o_desc_valid.
- i_frame_start: next cycle FIFO empty, in-flight=0, state IDLE, o_desc_valid=0. It takes priority over push and pop in the same cycle. Counters are not cleared.
- Reset mid-operation: everything returns to reset values asynchronously.

Optional Feature:
- Macro: BRIEF_SCHED_STATS_EN
- Defined:
  - Adds outputs o_stale_cnt[15:0], o_ovf_cnt[15:0] and o_spur_cnt[15:0].
  - Each counter increments on stale drop, output overflow, or spurious flag respectively.
  - Counters saturate at 16'hFFFF and clear only on reset.
- Undefined: ports absent; drops are silent; behaviour otherwise identical.

Test Plan:
- Push (10,5),(20,5). Sweep window raster from (0,5). At win (10,5): o_brief_coor=(10,5) and pop. Next cycle the head is (20,5). Flag 3 cycles later → o_desc_valid=1, o_desc_x=10.
- Push (12,4). Window already at (15,4) → popped as stale, never issued; o_stale_cnt=1 (stats on); o_busy drops to 0.
- Push (30,7),(31,7),(32,7). Window advances every cycle → three consecutive issues. In-flight peaks at 3. Three flags with i_desc_ready=1 → three descriptors, in order.
- Hold i_desc_ready=0, deliver two flags → first descriptor retained, o_ovf_cnt=1, in-flight returns to 0.
- Fill FIFO to 8 → o_kp_ready=0. Pulse i_frame_start together with i_kp_valid → next cycle FIFO empty, o_kp_ready=1, state IDLE, o_desc_valid=0.
- Push (0,9) → discarded, FIFO stays empty. Flag with in-flight 0 → ignored, o_spur_cnt=1, o_desc_valid stays 0.
